// File: rtl/cell_enable_ctrl.sv
// cell_enable_ctrl
//   Move-decode controller for the tic-tac-toe board. Accepts a cell index
//   over a valid/ready handshake, range/occupancy checks it and issues a
//   registered one-cycle one-hot enable to the addressed cell register.
//   Tracks occupancy, turn, move count and a full-board flag.
//
//   Build option: define CELL_OCCUPANCY_CHECK_EN to refuse moves onto
//   occupied cells; when undefined only the range check applies.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   clear      synchronous game restart (highest priority)
//   sel_valid  move request present
//   sel        zero-based requested cell index
//   sel_ready  request can be accepted this cycle
//   en         one-hot write-enable pulse to cell registers
//   player     player of the granted move (0 = X, 1 = O), valid with accept
//   accept     one-cycle pulse on grant
//   reject     one-cycle pulse on refusal
//   occupied   board occupancy map
//   moves      number of granted moves (saturates at CELLS)
//   full       every cell occupied / move budget used
module cell_enable_ctrl #(
  parameter int CELLS = 9,
  parameter int SEL_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         sel_valid,
  input  logic [SEL_W-1:0]             sel,
  output logic                         sel_ready,
  output logic [CELLS-1:0]             en,
  output logic                         player,
  output logic                         accept,
  output logic                         reject,
  output logic [CELLS-1:0]             occupied,
  output logic [$clog2(CELLS+1)-1:0]   moves,
  output logic                         full
);

  localparam int MW = $clog2(CELLS+1);
  localparam logic [MW-1:0] FULL_CNT = MW'(CELLS);

  typedef enum logic [1:0] {IDLE, RESP, DONE} state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_en;
  logic             r_player;
  logic             r_accept;
  logic             r_reject;
  logic [CELLS-1:0] r_occ;
  logic [MW-1:0]    r_moves;
  logic             r_full;
  logic             r_turn;

  logic             w_in_range;
  logic [CELLS-1:0] w_onehot;
  logic             w_grant;
`ifdef CELL_OCCUPANCY_CHECK_EN
  logic             w_hit;
`endif

  // One extra bit on both sides so CELLS == 2^SEL_W still compares correctly.
  always_comb begin
    w_in_range = ({1'b0, sel} < (SEL_W+1)'(CELLS));
    w_onehot   = '0;
`ifdef CELL_OCCUPANCY_CHECK_EN
    w_hit      = 1'b0;
`endif
    // Decode only in-range indices, so an out-of-range sel yields no bit.
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (sel == SEL_W'(i)) begin
        w_onehot[i] = 1'b1;
`ifdef CELL_OCCUPANCY_CHECK_EN
        w_hit       = r_occ[i];
`endif
      end
    end
`ifdef CELL_OCCUPANCY_CHECK_EN
    w_grant = w_in_range && !w_hit;
`else
    w_grant = w_in_range;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_en     <= '0;
      r_player <= 1'b0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_occ    <= '0;
      r_moves  <= '0;
      r_full   <= 1'b0;
      r_turn   <= 1'b0;
    end else if (clear) begin
      r_state  <= IDLE;
      r_en     <= '0;
      r_player <= 1'b0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_occ    <= '0;
      r_moves  <= '0;
      r_full   <= 1'b0;
      r_turn   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sel_valid) begin
            r_state <= RESP;
            if (w_grant) begin
              r_en     <= w_onehot;
              r_accept <= 1'b1;
              r_player <= r_turn;
              r_turn   <= ~r_turn;
              r_occ    <= r_occ | w_onehot;
              if (r_moves != FULL_CNT) r_moves <= r_moves + 1'b1;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        RESP: begin
          r_en     <= '0;
          r_accept <= 1'b0;
          r_reject <= 1'b0;
          if (r_moves == FULL_CNT) begin
            r_state <= DONE;
            r_full  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel_ready = (r_state == IDLE) && !clear;
  assign en        = r_en;
  assign player    = r_player;
  assign accept    = r_accept;
  assign reject    = r_reject;
  assign occupied  = r_occ;
  assign moves     = r_moves;
  assign full      = r_full;

endmodule

// File: tb/tb_cell_enable_ctrl.sv
module tb_cell_enable_ctrl;

  logic clk = 1'b0;
  logic rst, clear;

  logic       a_valid, a_ready, a_player, a_accept, a_reject, a_full;
  logic [3:0] a_sel, a_moves;
  logic [8:0] a_en, a_occ;

  logic        b_valid, b_ready, b_player, b_accept, b_reject, b_full;
  logic [3:0]  b_sel;
  logic [4:0]  b_moves;
  logic [15:0] b_en, b_occ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cell_enable_ctrl #(.CELLS(9), .SEL_W(4)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .sel_valid(a_valid), .sel(a_sel),
    .sel_ready(a_ready), .en(a_en), .player(a_player), .accept(a_accept),
    .reject(a_reject), .occupied(a_occ), .moves(a_moves), .full(a_full)
  );

  cell_enable_ctrl #(.CELLS(16), .SEL_W(4)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .sel_valid(b_valid), .sel(b_sel),
    .sel_ready(b_ready), .en(b_en), .player(b_player), .accept(b_accept),
    .reject(b_reject), .occupied(b_occ), .moves(b_moves), .full(b_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request on DUT A for one edge; return sampled in RESP.
  task automatic req_a(input logic [3:0] s);
    a_sel = s;
    a_valid = 1'b1;
    cyc();
    a_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0;
    a_valid = 1'b0; a_sel = '0;
    b_valid = 1'b0; b_sel = '0;
    repeat (2) cyc();

    // Reset values
    chk("rst_en", a_en, 0);
    chk("rst_accept", a_accept, 0);
    chk("rst_reject", a_reject, 0);
    chk("rst_player", a_player, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_moves", a_moves, 0);
    chk("rst_full", a_full, 0);
    rst = 1'b1;
    #1;
    chk("rst_ready", a_ready, 1);

    // First grant, X moves first
    req_a(4'd4);
    chk("g4_en", a_en, 9'b000010000);
    chk("g4_accept", a_accept, 1);
    chk("g4_player", a_player, 0);
    chk("g4_occ", a_occ, 9'h010);
    chk("g4_moves", a_moves, 1);
    chk("g4_ready_resp", a_ready, 0);
    cyc();
    chk("g4_pulse_end_en", a_en, 0);
    chk("g4_pulse_end_acc", a_accept, 0);
    chk("g4_ready_idle", a_ready, 1);

    // Repeat onto occupied cell 4
    req_a(4'd4);
`ifdef CELL_OCCUPANCY_CHECK_EN
    chk("occ_reject", a_reject, 1);
    chk("occ_en", a_en, 0);
    chk("occ_moves", a_moves, 1);
`else
    chk("rew_accept", a_accept, 1);
    chk("rew_en", a_en, 9'h010);
    chk("rew_player", a_player, 1);
    chk("rew_moves", a_moves, 2);
`endif
    cyc();

    // Out of range
    req_a(4'd9);
    chk("oor9_reject", a_reject, 1);
    chk("oor9_en", a_en, 0);
    chk("oor9_occ", a_occ, 9'h010);
    cyc();
    req_a(4'd15);
    chk("oor15_reject", a_reject, 1);
    chk("oor15_en", a_en, 0);
    cyc();
    chk("oor_ready", a_ready, 1);

    // Next grant: turn depends on whether the repeat was granted
    req_a(4'd0);
    chk("g0_accept", a_accept, 1);
    chk("g0_en", a_en, 9'h001);
`ifdef CELL_OCCUPANCY_CHECK_EN
    chk("g0_player", a_player, 1);
    chk("g0_moves", a_moves, 2);
`else
    chk("g0_player", a_player, 0);
    chk("g0_moves", a_moves, 3);
`endif
    cyc();

    // Clear together with a request: request dropped
    clear = 1'b1; a_valid = 1'b1; a_sel = 4'd1;
    #1;
    chk("clr_ready_low", a_ready, 0);
    cyc();
    clear = 1'b0; a_valid = 1'b0;
    #1;
    chk("clr_occ", a_occ, 0);
    chk("clr_moves", a_moves, 0);
    chk("clr_accept", a_accept, 0);
    chk("clr_en", a_en, 0);
    chk("clr_ready", a_ready, 1);
    cyc();
    chk("clr_dropped", a_accept, 0);

    // Fill the board in order
    for (int i = 0; i < 9; i++) begin
      req_a(4'(i));
      chk("fill_accept", a_accept, 1);
      chk("fill_player", a_player, 32'(i % 2));
      chk("fill_en", a_en, 32'(1 << i));
      chk("fill_moves", a_moves, 32'(i + 1));
      chk("fill_full_early", a_full, 0);
      cyc();
    end
    chk("full_flag", a_full, 1);
    chk("full_ready", a_ready, 0);
    chk("full_occ", a_occ, 9'h1FF);
    chk("full_moves", a_moves, 9);

    // Requests in DONE get no response
    a_sel = 4'd3; a_valid = 1'b1;
    cyc();
    chk("done_acc", a_accept, 0);
    chk("done_rej", a_reject, 0);
    cyc();
    chk("done_en", a_en, 0);
    chk("done_rej2", a_reject, 0);
    a_valid = 1'b0;

    // Clear out of DONE
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    #1;
    chk("dclr_full", a_full, 0);
    chk("dclr_moves", a_moves, 0);
    chk("dclr_occ", a_occ, 0);
    chk("dclr_ready", a_ready, 1);

    // Reset during RESP kills the pulse immediately
    req_a(4'd2);
    chk("mid_accept_pre", a_accept, 1);
    rst = 1'b0;
    #1;
    chk("mid_accept", a_accept, 0);
    chk("mid_en", a_en, 0);
    chk("mid_occ", a_occ, 0);
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_ready", a_ready, 1);

    // 16-cell instance: top index and a repeat onto it
    b_sel = 4'd15; b_valid = 1'b1;
    cyc();
    b_valid = 1'b0;
    chk("b15_en", b_en, 16'h8000);
    chk("b15_accept", b_accept, 1);
    chk("b15_moves", b_moves, 1);
    cyc();
    b_valid = 1'b1;
    cyc();
    b_valid = 1'b0;
`ifdef CELL_OCCUPANCY_CHECK_EN
    chk("b15r_reject", b_reject, 1);
    chk("b15r_moves", b_moves, 1);
`else
    chk("b15r_accept", b_accept, 1);
    chk("b15r_en", b_en, 16'h8000);
    chk("b15r_moves", b_moves, 2);
`endif
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_enable_ctrl.md
# cell_enable_ctrl

Registered, parametrised move-decode controller for the tic-tac-toe board. It accepts a cell index through a valid/ready handshake, checks the index for range and occupancy, and issues a one-cycle one-hot enable to the addressed cell register. It tracks board occupancy, the player whose turn it is, and the move count, and it flags a full board. It sits between the input/keypad logic and the per-cell storage registers, and replaces the old combinational index-to-enable decode.

## Interface
- `CELLS`, default 9: number of board cells, legal range 2..16.
- `SEL_W`, default 4: width of the cell index; it must satisfy 2^SEL_W ≥ CELLS.
- `clk` in, 1 bit: single clock; all state changes on the rising edge.
- `rst` in, 1 bit: one clock; reset is asynchronous and active-low.
- `clear` in, 1 bit: synchronous game restart.
- `sel_valid` in, 1 bit: a move request is present.
- `sel` in, SEL_W bits: zero-based cell index of the requested move.
- `sel_ready` out, 1 bit: the block can accept a request this cycle.
- `en` out, CELLS bits: one-hot write-enable pulse to the cell registers.
- `player` out, 1 bit: the player whose move was just granted, valid while `accept` is high. 0 is X, 1 is O.
- `accept` out, 1 bit: one-cycle pulse when a move is granted.
- `reject` out, 1 bit: one-cycle pulse when a move is refused.
- `occupied` out, CELLS bits: occupancy map of the board.
- `moves` out, $clog2(CELLS+1) bits: count of granted moves.
- `full` out, 1 bit: high when every cell is occupied.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - RESP: the one-cycle response slot.
  - DONE: the board is full.
- `sel_ready` = (state == IDLE) and not `clear`.
- **IDLE:** a request is taken when `sel_valid && sel_ready` at a rising edge. The state moves to RESP, and on that same edge `en`, `accept`/`reject` and `player` are registered.
- **Grant condition:** `sel` < CELLS and `occupied[sel]` == 0. The occupancy part applies only when occupancy checking is compiled in; see Configuration.
- **On grant:**
  - `en` = 1 << `sel`; `accept` = 1.
  - `occupied[sel]` is set and `moves` increments.
  - `player` outputs the current turn bit, then the internal turn bit toggles.
- **On refusal:** `en` = 0, `reject` = 1. Occupancy, `moves` and the turn bit are unchanged.
- **RESP:**
  - `en`, `accept` and `reject` return to 0 on the next edge.
  - The state moves to DONE if `moves` == CELLS, otherwise to IDLE.
  - `sel_valid` is ignored while in RESP.
- **DONE:**
  - `full` = 1 and `sel_ready` = 0; requests are ignored, and no `reject` is generated.
  - The state leaves DONE only through `clear`.
- **`clear`:** highest priority, in any state. On the next edge:
  - state becomes IDLE;
  - `occupied`, `moves`, the turn bit, `en`, `accept` and `reject` are all 0.
  - A request presented together with `clear` is dropped.
- **`moves` width:** it saturates at CELLS and never wraps.
- **`full`:** a registered output equal to (`moves` == CELLS).

## Timing
- **Reset values** (`rst` low, asynchronous): state IDLE; `en` 0, `accept` 0, `reject` 0, `player` 0, `occupied` 0, `moves` 0, `full` 0; internal turn bit 0, so X moves first.
- `sel_ready` is 1 after reset deassertion.
- **Latency:** the request edge and the `en`/`accept` pulse are one edge apart; the pulse lasts exactly one cycle.
- **Throughput:** at most one request per two cycles.
- **`occupied`/`moves` update:** on the same edge that raises `accept`.
- **`full`:** rises on the edge that ends the final RESP cycle.
- **Reset mid-operation:** reset asserted during RESP clears the pending pulse immediately, and no enable is issued.

## Configuration
- Macro: `CELL_OCCUPANCY_CHECK_EN`.
- **Defined:** a request to an occupied cell is refused (`reject`, no `en`).
- **Undefined:**
  - Only the range check applies, so occupied cells may be rewritten.
  - A rewrite still pulses `en` and `accept`, toggles the turn bit and increments `moves`.
  - `occupied` stays set, and `full` follows `moves` == CELLS.

## Test plan
- **Reset:** hold `rst` low, then release. Required: all outputs 0, `sel_ready` = 1. Then request `sel`=4. Required: `en` = 9'b000010000, `accept` = 1, `player` = 0 for one cycle; `occupied` = 9'h010; `moves` = 1.
- **Occupied cell, macro defined:** request `sel`=4 again. Required: `reject` = 1, `en` = 0, `moves` stays 1; the next grant shows `player` = 1.
- **Out of range:** `sel`=9 or `sel`=15. Required: `reject` = 1, no `en` bit set, state unchanged.
- **Fill the board:** request cells 0..8 in order. Required: `player` alternates 0,1,0,…; `moves` = 9; `full` = 1; `sel_ready` = 0; a further request gets no response.
- **Clear:** assert `clear` in DONE, and separately together with `sel_valid`. Required: next cycle `occupied` = 0, `moves` = 0, IDLE, `sel_ready` = 1; the concurrent request is dropped.
- **Parameters and macro:** `CELLS`=16, `SEL_W`=4, macro undefined. Required: `sel`=15 gives `en` = 16'h8000; a repeat of `sel`=15 is accepted and `moves` reaches 2.
